// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared types and constants for the table-driven I2C write master.
//   state_t       : sequencer FSM states
//   PHASES        : SCL quarter-phase ticks per START/bit/ACK/STOP slot
//   BYTES_PER_TXN : bytes per register write (dev addr+W, reg addr, data)
//   MAX_TXN       : largest supported table depth
//   tbl_t         : table zero-extended to MAX_TXN entries
//   tbl_entry()   : pick byte entry idx out of a packed table
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_GAP,
    S_FINISH
  } state_t;

  localparam int PHASES        = 4;
  localparam int BYTES_PER_TXN = 3;
  localparam int MAX_TXN       = 16;

  typedef logic [MAX_TXN*8-1:0] tbl_t;

  // Entry idx lives at bits [8*idx+7 : 8*idx].
  function automatic logic [7:0] tbl_entry(input tbl_t tbl, input logic [3:0] idx);
    return tbl[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// i2c_tick_gen
// Divides the system clock into a one-cycle tick every CLK_DIV clocks.
// The counter is held at zero whenever the enable is low or the clear is
// asserted, so the first tick after enabling arrives CLK_DIV clocks later.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   i_en   : run the divider
//   i_clr  : synchronous clear of the divider
//   o_tick : one-cycle enable, high on the last count of each period
// ---------------------------------------------------------------------------
module i2c_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/i2c_seq_writer.sv
// ---------------------------------------------------------------------------
// i2c_seq_writer
// Table-driven I2C write master. A start pulse launches NUM_TXN single-byte
// register writes (START, dev addr+W, reg addr, data, STOP) to DEV_ADDR.
// Every ACK slot is checked; a NACK aborts the entry with a STOP and the
// entry is retried up to MAX_RETRY times before the sequence gives up.
// All line changes happen on divider ticks; each START/bit/ACK/STOP slot is
// four ticks (quarter phases of SCL).
//
// Ports
//   clk, rst      : system clock, synchronous active-high reset
//   start         : one-cycle pulse, accepted only while idle
//   reg_addr_tbl  : entry i register address at [8i+7:8i]
//   data_tbl      : entry i write data at [8i+7:8i]
//   sda_i         : synchronised SDA pad input
//   scl_oe/sda_oe : 1 pulls the open-drain line low
//   busy          : sequence in progress
//   done          : one-cycle pulse when every entry was ACKed
//   error         : sticky retry-exhaustion flag, cleared by next start
//   txn_idx       : current / failing entry
//   nack_cnt      : saturating NACK count since the last start
// ---------------------------------------------------------------------------
module i2c_seq_writer
  import i2c_seq_pkg::*;
#(
  parameter int         NUM_TXN   = 7,
  parameter logic [6:0] DEV_ADDR  = 7'h0A,
  parameter int         CLK_DIV   = 4,
  parameter int         GAP_TICKS = 8,
  parameter int         MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_TXN*8-1:0] reg_addr_tbl,
  input  logic [NUM_TXN*8-1:0] data_tbl,
  input  logic                 sda_i,
  output logic                 scl_oe,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [3:0]           txn_idx,
  output logic [7:0]           nack_cnt
);

  localparam int            GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  localparam logic [3:0]    TXN_LAST = 4'(NUM_TXN - 1);
  localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);
  localparam logic [1:0]    BYTE_LAST = 2'(BYTES_PER_TXN - 1);

  state_t        r_state;
  logic [1:0]    r_phase;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic          r_nack;
  logic [2:0]    r_retry;
  logic [GW-1:0] r_gap;
  logic          r_advance;
  logic          r_scl_oe;
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [3:0]    r_txn;
  logic [7:0]    r_nack_cnt;

  tbl_t          r_reg_tbl;
  tbl_t          r_dat_tbl;

  logic          w_accept;
  logic          w_tick;
  logic [7:0]    w_cur_byte;

  assign w_accept = (r_state == S_IDLE) && start;

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_busy),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  // Tables are captured once per sequence so the host may change them
  // while the sequence runs.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_reg_tbl <= tbl_t'(reg_addr_tbl);
      r_dat_tbl <= tbl_t'(data_tbl);
    end
  end

  // Byte currently being shifted out.
  always_comb begin
    w_cur_byte = {DEV_ADDR, 1'b0};
    case (r_byte)
      2'd1:    w_cur_byte = tbl_entry(r_reg_tbl, r_txn);
      2'd2:    w_cur_byte = tbl_entry(r_dat_tbl, r_txn);
      default: w_cur_byte = {DEV_ADDR, 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_nack     <= 1'b0;
      r_retry    <= '0;
      r_gap      <= '0;
      r_advance  <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_txn      <= '0;
      r_nack_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state    <= S_START;
        r_phase    <= '0;
        r_byte     <= '0;
        r_nack     <= 1'b0;
        r_retry    <= '0;
        r_gap      <= '0;
        r_advance  <= 1'b0;
        r_busy     <= 1'b1;
        r_error    <= 1'b0;
        r_txn      <= '0;
        r_nack_cnt <= '0;
      end else if (w_tick) begin
        case (r_state)
          // Both lines high for two ticks, then SDA falls with SCL high.
          S_START: begin
            r_phase  <= r_phase + 2'd1;
            r_scl_oe <= 1'b0;
            r_sda_oe <= r_phase[1];
            if (r_phase == 2'd3) begin
              r_state <= S_BIT;
              r_bit   <= 3'd7;
              r_byte  <= '0;
              r_nack  <= 1'b0;
            end
          end

          // SDA only moves on tick 0, while SCL is being pulled low.
          S_BIT: begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd0: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= ~w_cur_byte[r_bit];
              end
              2'd1:    r_scl_oe <= 1'b1;
              2'd2:    r_scl_oe <= 1'b0;
              default: begin
                r_scl_oe <= 1'b0;
                if (r_bit == 3'd0) begin
                  r_state <= S_ACK;
                end else begin
                  r_bit <= r_bit - 3'd1;
                end
              end
            endcase
          end

          // SDA released for the slave; its level is taken as SCL rises.
          S_ACK: begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd0: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= 1'b0;
              end
              2'd1: r_scl_oe <= 1'b1;
              2'd2: begin
                r_scl_oe <= 1'b0;
                if (sda_i) begin
                  r_nack <= 1'b1;
                  if (r_nack_cnt != 8'hFF) begin
                    r_nack_cnt <= r_nack_cnt + 8'd1;
                  end
                end
              end
              default: begin
                r_scl_oe <= 1'b0;
                if (r_nack || (r_byte == BYTE_LAST)) begin
                  r_state <= S_STOP;
                end else begin
                  r_state <= S_BIT;
                  r_byte  <= r_byte + 2'd1;
                  r_bit   <= 3'd7;
                end
              end
            endcase
          end

          // SDA held low under SCL low, SCL released, then SDA rises.
          S_STOP: begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd0: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= 1'b1;
              end
              2'd1: r_scl_oe <= 1'b0;
              2'd2: r_sda_oe <= 1'b0;
              default: begin
                r_sda_oe <= 1'b0;
                r_gap    <= '0;
                if (r_nack) begin
                  if (r_retry < RETRY_LIM) begin
                    r_retry   <= r_retry + 3'd1;
                    r_advance <= 1'b0;
                    r_state   <= S_GAP;
                  end else begin
                    r_error <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                  end
                end else if (r_txn == TXN_LAST) begin
                  r_state <= S_FINISH;
                end else begin
                  r_advance <= 1'b1;
                  r_state   <= S_GAP;
                end
              end
            endcase
          end

          // Bus idle between entries; the entry index moves on only after
          // a fully ACKed entry.
          S_GAP: begin
            if (r_gap == GAP_LAST) begin
              r_gap   <= '0;
              r_phase <= '0;
              r_state <= S_START;
              if (r_advance) begin
                r_txn   <= r_txn + 4'd1;
                r_retry <= '0;
              end
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end

          S_FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign scl_oe   = r_scl_oe;
  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign txn_idx  = r_txn;
  assign nack_cnt = r_nack_cnt;

endmodule

// File: tb/tb_i2c_seq_writer.sv
// ---------------------------------------------------------------------------
// tb_i2c_seq_writer
// Scoreboard bench: stimulus queues expected bytes and scalar checks; a bus
// monitor (which also plays the I2C slave) decodes the open-drain lines and
// compares everything it sees against the queues.
// ---------------------------------------------------------------------------
module tb_i2c_seq_writer;

  localparam int         NUM_TXN   = 2;
  localparam logic [6:0] DEV_ADDR  = 7'h0A;
  localparam int         CLK_DIV   = 2;
  localparam int         GAP_TICKS = 4;
  localparam int         MAX_RETRY = 2;
  // first tick CLK_DIV clks after acceptance, done 472 clks after that
  localparam int         DONE_LAT  = 2 + 472;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] reg_addr_tbl;
  logic [15:0] data_tbl;
  logic        sda_i;
  logic        scl_oe;
  logic        sda_oe;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  txn_idx;
  logic [7:0]  nack_cnt;

  i2c_seq_writer #(
    .NUM_TXN   (NUM_TXN),
    .DEV_ADDR  (DEV_ADDR),
    .CLK_DIV   (CLK_DIV),
    .GAP_TICKS (GAP_TICKS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .reg_addr_tbl (reg_addr_tbl),
    .data_tbl     (data_tbl),
    .sda_i        (sda_i),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .txn_idx      (txn_idx),
    .nack_cnt     (nack_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // open-drain bus with slave pull-down
  logic r_pull;
  assign sda_i = ~(sda_oe | r_pull);

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] exp_q[$];

  // monitor-owned state
  int         total, bad;
  int         chk_rd, rd_idx;
  int         bitcnt, bytecnt;
  int         starts, stops, done_cnt, done_cyc;
  int         used_tok;
  logic [7:0] shreg;
  logic       prev_scl, prev_sda, scl_now, sda_now, mon_nack;

  // stimulus-owned state
  int         mode;     // 0 ack all, 1 nack data byte once, 2 nack dev addr
  int         req_tok;
  int         t0;

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    post(nm, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Bus monitor, slave model and scoreboard.
  initial begin
    total = 0; bad = 0; chk_rd = 0; rd_idx = 0;
    bitcnt = 0; bytecnt = 0; starts = 0; stops = 0;
    done_cnt = 0; done_cyc = 0; used_tok = 0;
    shreg = '0; r_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    forever begin
      @(negedge clk);
      while (chk_rd < chk_q.size()) begin
        total++;
        if (chk_q[chk_rd].act !== chk_q[chk_rd].exp) begin
          bad++;
          $display("FAIL %s: got %0d want %0d", chk_q[chk_rd].name,
                   chk_q[chk_rd].act, chk_q[chk_rd].exp);
        end
        chk_rd++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      scl_now = ~scl_oe;
      sda_now = sda_i;
      if (rst) begin
        bitcnt = 0;
        bytecnt = 0;
        r_pull = 1'b0;
      end else if (prev_scl && scl_now && prev_sda && !sda_now) begin
        starts++;
        bitcnt = 0;
        bytecnt = 0;
      end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
        stops++;
        r_pull = 1'b0;
      end else if (!prev_scl && scl_now) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], sda_now};
          bitcnt++;
          if (bitcnt == 8) begin
            total++;
            if (rd_idx >= exp_q.size()) begin
              bad++;
              $display("FAIL byte: got unexpected %02h, queue empty", shreg);
            end else begin
              if (shreg !== exp_q[rd_idx]) begin
                bad++;
                $display("FAIL byte[%0d]: got %02h want %02h", rd_idx, shreg, exp_q[rd_idx]);
              end
              rd_idx++;
            end
          end
        end else begin
          bitcnt = 0;
          bytecnt++;
        end
      end else if (prev_scl && !scl_now) begin
        if (bitcnt == 8) begin
          mon_nack = (mode == 2 && bytecnt == 0) ||
                     (mode == 1 && bytecnt == 2 && used_tok != req_tok);
          if (mode == 1 && bytecnt == 2) used_tok = req_tok;
          r_pull = !mon_nack;
        end else begin
          r_pull = 1'b0;
        end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got busy=%0b want idle", busy);
    $fatal(1, "watchdog");
  end

  int d0, s0, p0;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0; req_tok = 0; t0 = 0;
    reg_addr_tbl = '0; data_tbl = '0;

    // reset hold with start toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    post("rst_scl_oe",   {31'd0, scl_oe}, 32'd0);
    post("rst_sda_oe",   {31'd0, sda_oe}, 32'd0);
    post("rst_busy",     {31'd0, busy},   32'd0);
    post("rst_done",     {31'd0, done},   32'd0);
    post("rst_error",    {31'd0, error},  32'd0);
    post("rst_txn_idx",  {28'd0, txn_idx}, 32'd0);
    post("rst_nack_cnt", {24'd0, nack_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    post("post_rst_busy", {31'd0, busy}, 32'd0);

    // clean two-entry sequence: entry0 05:50, entry1 04:00
    reg_addr_tbl = {8'h04, 8'h05};
    data_tbl     = {8'h00, 8'h50};
    mode = 0;
    push_bytes(8'h14, 8'h05, 8'h50);
    push_bytes(8'h14, 8'h04, 8'h00);
    d0 = done_cnt;
    pulse_start();
    wait_idle("clean_timeout", 2000);
    post("clean_done_cnt", done_cnt - d0, 32'd1);
    post("clean_done_lat", done_cyc - t0, DONE_LAT);
    post("clean_error",    {31'd0, error}, 32'd0);
    post("clean_nack_cnt", {24'd0, nack_cnt}, 32'd0);
    post("clean_txn_idx",  {28'd0, txn_idx}, 32'd1);
    post("clean_bytes",    rd_idx, exp_q.size());

    // data byte of entry 0 NACKed once, then recovered
    mode = 1;
    req_tok++;
    push_bytes(8'h14, 8'h05, 8'h50);
    push_bytes(8'h14, 8'h05, 8'h50);
    push_bytes(8'h14, 8'h04, 8'h00);
    d0 = done_cnt;
    s0 = starts;
    pulse_start();
    wait_idle("retry_timeout", 3000);
    post("retry_done_cnt", done_cnt - d0, 32'd1);
    post("retry_nack_cnt", {24'd0, nack_cnt}, 32'd1);
    post("retry_error",    {31'd0, error}, 32'd0);
    post("retry_starts",   starts - s0, 32'd3);
    post("retry_bytes",    rd_idx, exp_q.size());

    // device address always NACKed: retries exhausted
    mode = 2;
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h14);
    d0 = done_cnt;
    s0 = starts;
    p0 = stops;
    pulse_start();
    wait_idle("exhaust_timeout", 3000);
    post("exhaust_error",    {31'd0, error}, 32'd1);
    post("exhaust_busy",     {31'd0, busy}, 32'd0);
    post("exhaust_txn_idx",  {28'd0, txn_idx}, 32'd0);
    post("exhaust_nack_cnt", {24'd0, nack_cnt}, 32'd3);
    post("exhaust_done_cnt", done_cnt - d0, 32'd0);
    post("exhaust_starts",   starts - s0, 32'd3);
    post("exhaust_stops",    stops - p0, 32'd3);
    post("exhaust_bytes",    rd_idx, exp_q.size());

    // second start while busy is ignored
    mode = 0;
    push_bytes(8'h14, 8'h05, 8'h50);
    push_bytes(8'h14, 8'h04, 8'h00);
    d0 = done_cnt;
    pulse_start();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start_timeout", 2000);
    post("busy_start_done_cnt", done_cnt - d0, 32'd1);
    post("busy_start_done_lat", done_cyc - t0, DONE_LAT);
    post("busy_start_error",    {31'd0, error}, 32'd0);
    post("busy_start_bytes",    rd_idx, exp_q.size());

    // reset in the middle of entry 1's data byte
    push_bytes(8'h14, 8'h05, 8'h50);
    exp_q.push_back(8'h14);
    exp_q.push_back(8'h04);
    pulse_start();
    repeat (410) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    post("midrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    post("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
    post("midrst_busy",   {31'd0, busy},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    post("midrst_bytes", rd_idx, exp_q.size());
    push_bytes(8'h14, 8'h05, 8'h50);
    push_bytes(8'h14, 8'h04, 8'h00);
    d0 = done_cnt;
    pulse_start();
    wait_idle("replay_timeout", 2000);
    post("replay_done_cnt", done_cnt - d0, 32'd1);
    post("replay_error",    {31'd0, error}, 32'd0);
    post("replay_bytes",    rd_idx, exp_q.size());

    for (int n = 0; n < 20 && chk_rd < chk_q.size(); n++) @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
